cv32e41s_wpt_filter: RTL and testbench
======================================

Name: cv32e41s_wpt_filter

Overview:
Parametrised successor of the load/store watchpoint-trigger filter. It sits between the LSU's OBI-side request path and the MPU interface. Transfers that hit a watchpoint trigger are consumed locally instead of going out on the bus. When the core requests it, a synthetic response is returned only after all in-flight bus transfers have drained. Unlike the previous generation, it tracks outstanding transactions itself with an internal counter, caps that count at a configurable depth, and supports an arbitrary number of triggers and payload widths.

Parameters:
NUM_TRIGGERS, 4, number of watchpoint triggers (1..32); width of all match vectors.
MAX_OUTSTANDING, 2, maximum bus transfers in flight (1..7).
REQ_W, 72, width of the opaque request payload forwarded to the MPU.
RSP_W, 40, width of the opaque response payload (bus response plus MPU status).
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; not overridden).

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
trigger_match_i  input  NUM_TRIGGERS  per-trigger match for the current core request
core_trans_valid_i  input  1  core request valid
core_trans_ready_o  output  1  core request accepted
core_trans_i  input  REQ_W  core request payload
mpu_trans_valid_o  output  1  request valid towards MPU
mpu_trans_ready_i  input  1  MPU accepts request
mpu_trans_o  output  REQ_W  request payload towards MPU (core_trans_i passthrough)
mpu_resp_valid_i  input  1  MPU response valid
mpu_resp_i  input  RSP_W  MPU response payload
core_resp_valid_o  output  1  response valid towards core
core_resp_o  output  RSP_W  response payload towards core
core_resp_wpt_o  output  NUM_TRIGGERS  trigger(s) reported with the response
core_wpt_wait_i  input  1  1: report match with response after drain; 0: consume silently
core_wpt_match_o  output  NUM_TRIGGERS  immediate match report (= trigger_match_i)
outstanding_o  output  CNT_W  current outstanding bus transfer count

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, match_q=0, cnt=0. All registered outputs are 0; outstanding_o=0; core_resp_wpt_o=0. Reset mid-WAIT or mid-RESP drops the pending match with no response.
- bus_fire = mpu_trans_valid_o && mpu_trans_ready_i. cnt_n = cnt + bus_fire - mpu_resp_valid_i. No wrap: the cap guarantees cnt never exceeds MAX_OUTSTANDING. A response while cnt=0 is illegal and covered by an assertion.
- cap = (cnt == MAX_OUTSTANDING). While cap is set, mpu_trans_valid_o=0 even if a response arrives in the same cycle.
- hit = |trigger_match_i && core_trans_valid_i.
- IDLE:
  - If hit: mpu_trans_valid_o=0, core_trans_ready_o=1 (consumed, even when cap is set), match_q<=trigger_match_i.
    - If core_wpt_wait_i: next state RESP when cnt_n==0, else WAIT.
    - If !core_wpt_wait_i: stay in IDLE; no response is ever generated.
  - Else: mpu_trans_valid_o = core_trans_valid_i && !cap; core_trans_ready_o = mpu_trans_ready_i && !cap.
- WAIT: block both sides (mpu_trans_valid_o=0, core_trans_ready_o=0). Go to RESP when cnt_n==0.
- RESP: still blocked. core_resp_valid_o=1, core_resp_o=0, core_resp_wpt_o=match_q. match_q<=0. Unconditionally return to IDLE (the core is always ready). Minimum latency from hit to response is 1 cycle, with no drain.
- Response forwarding: core_resp_valid_o = mpu_resp_valid_i || (state==RESP). core_resp_o = mpu_resp_i when mpu_resp_valid_i, else 0. core_resp_wpt_o=0 outside RESP. An MPU response and RESP in the same cycle cannot occur (cnt=0 in RESP) and is covered by an assertion.
- Response ordering: every MPU response for transfers issued before a hit reaches the core strictly before the synthetic response.
- Passthrough: mpu_trans_o = core_trans_i and core_wpt_match_o = trigger_match_i, both combinational. outstanding_o = cnt (registered).
- Trigger bits above the implemented triggers do not exist; width is exactly NUM_TRIGGERS.

Test Plan:
- Clean hit, cnt=0, wait=1, trigger_match_i=4'b0010 -> ready=1 and mpu_valid=0 in cycle 0; cycle 1 core_resp_valid=1, core_resp_wpt=4'b0010, core_resp=0; back to IDLE.
- Two transfers in flight (MAX_OUTSTANDING=2), then a hit with wait=1 -> state WAIT; MPU responses at +3 and +5 are forwarded; synthetic response at +6 with the captured match; no new request is accepted before +7.
- Outstanding cap: issue 2 transfers with no responses -> third request sees ready=0 and mpu_valid=0; a response arrives -> request accepted the following cycle; outstanding_o sequence 1,2,2,1,2.
- Hit at cap: cnt=2 and hit with wait=1 -> ready=1 in the same cycle, WAIT until both responses arrive, then RESP.
- Silent consume: hit with wait=0, match=4'b1000 -> ready=1, core_wpt_match_o=4'b1000 the same cycle, no core_resp_valid afterwards, the next request passes normally.
- Reset in WAIT: assert rst for 1 cycle -> state IDLE, outstanding_o=0, no synthetic response is emitted afterwards.

Source files
------------

// File: rtl/cv32e41s_wpt_filter.sv
// ---------------------------------------------------------------------------
// cv32e41s_wpt_filter
//
// Load/store watchpoint-trigger filter between the LSU request path and the
// MPU. A core request that hits a watchpoint trigger is consumed here and
// never reaches the bus. If the core asks to wait, a synthetic response that
// carries the captured trigger match is returned, but only after every bus
// transfer already in flight has returned. The filter counts outstanding
// bus transfers itself and stops issuing new ones at MAX_OUTSTANDING.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   trigger_match_i           per-trigger match for the current core request
//   core_trans_valid_i/_ready_o/core_trans_i   core request handshake + payload
//   mpu_trans_valid_o/_ready_i/mpu_trans_o     request towards the MPU
//   mpu_resp_valid_i, mpu_resp_i               response from the MPU
//   core_resp_valid_o, core_resp_o, core_resp_wpt_o  response towards core
//   core_wpt_wait_i           1: report the hit after drain, 0: consume silently
//   core_wpt_match_o          immediate match report (trigger_match_i)
//   outstanding_o             registered outstanding bus transfer count
// ---------------------------------------------------------------------------
module cv32e41s_wpt_filter #(
    parameter int NUM_TRIGGERS    = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int REQ_W           = 72,
    parameter int RSP_W           = 40,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_TRIGGERS-1:0] trigger_match_i,
    input  logic                    core_trans_valid_i,
    output logic                    core_trans_ready_o,
    input  logic [REQ_W-1:0]        core_trans_i,
    output logic                    mpu_trans_valid_o,
    input  logic                    mpu_trans_ready_i,
    output logic [REQ_W-1:0]        mpu_trans_o,
    input  logic                    mpu_resp_valid_i,
    input  logic [RSP_W-1:0]        mpu_resp_i,
    output logic                    core_resp_valid_o,
    output logic [RSP_W-1:0]        core_resp_o,
    output logic [NUM_TRIGGERS-1:0] core_resp_wpt_o,
    input  logic                    core_wpt_wait_i,
    output logic [NUM_TRIGGERS-1:0] core_wpt_match_o,
    output logic [CNT_W-1:0]        outstanding_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_n;
    logic [NUM_TRIGGERS-1:0] match_q, match_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic                    cap;
    logic                    hit;
    logic                    bus_fire;

    // Plain passthroughs.
    assign mpu_trans_o      = core_trans_i;
    assign core_wpt_match_o = trigger_match_i;
    assign outstanding_o    = cnt_q;

    assign cap      = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign hit      = (|trigger_match_i) && core_trans_valid_i;
    assign bus_fire = mpu_trans_valid_o && mpu_trans_ready_i;

    // The cap keeps the count within 0..MAX_OUTSTANDING, so no saturation
    // logic is needed; the illegal underflow case is covered by an assertion.
    assign cnt_n = cnt_q + CNT_W'(bus_fire) - CNT_W'(mpu_resp_valid_i);

    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_n            = state_q;
        match_n            = match_q;
        mpu_trans_valid_o  = 1'b0;
        core_trans_ready_o = 1'b0;
        core_resp_wpt_o    = '0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    // Consumed locally, even while the bus side is capped.
                    core_trans_ready_o = 1'b1;
                    match_n            = trigger_match_i;
                    if (core_wpt_wait_i) begin
                        state_n = (cnt_n == '0) ? RESP : WAIT;
                    end
                end else begin
                    mpu_trans_valid_o  = core_trans_valid_i && !cap;
                    core_trans_ready_o = mpu_trans_ready_i && !cap;
                end
            end
            WAIT: begin
                if (cnt_n == '0) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                core_resp_wpt_o = match_q;
                match_n         = '0;
                state_n         = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus responses are forwarded combinationally; the synthetic response
    // carries an all-zero payload. Both never coincide (cnt is 0 in RESP).
    assign core_resp_valid_o = mpu_resp_valid_i || (state_q == RESP);
    assign core_resp_o       = mpu_resp_valid_i ? mpu_resp_i : '0;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            match_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            match_q <= match_n;
            cnt_q   <= cnt_n;
        end
    end

    // Protocol checks on the environment.
    a_no_resp_when_empty : assert property (@(posedge clk) disable iff (rst)
        mpu_resp_valid_i |-> (cnt_q != '0));

    a_no_resp_in_resp : assert property (@(posedge clk) disable iff (rst)
        (state_q == RESP) |-> !mpu_resp_valid_i);

    a_cnt_bounded : assert property (@(posedge clk) disable iff (rst)
        cnt_q <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_cv32e41s_wpt_filter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for cv32e41s_wpt_filter (default parameters:
// 4 triggers, 2 outstanding, 72-bit requests, 40-bit responses).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Every core response is checked in order against a queue of
// expected responses that the stimulus fills as it drives the DUT.
// ---------------------------------------------------------------------------
module tb_cv32e41s_wpt_filter;

    localparam int NT    = 4;
    localparam int MO    = 2;
    localparam int REQ_W = 72;
    localparam int RSP_W = 40;
    localparam int CNT_W = $clog2(MO + 1);

    typedef struct packed {
        logic [RSP_W-1:0] rsp;
        logic [NT-1:0]    wpt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NT-1:0]    trigger_match_i;
    logic             core_trans_valid_i;
    logic             core_trans_ready_o;
    logic [REQ_W-1:0] core_trans_i;
    logic             mpu_trans_valid_o;
    logic             mpu_trans_ready_i;
    logic [REQ_W-1:0] mpu_trans_o;
    logic             mpu_resp_valid_i;
    logic [RSP_W-1:0] mpu_resp_i;
    logic             core_resp_valid_o;
    logic [RSP_W-1:0] core_resp_o;
    logic [NT-1:0]    core_resp_wpt_o;
    logic             core_wpt_wait_i;
    logic [NT-1:0]    core_wpt_match_o;
    logic [CNT_W-1:0] outstanding_o;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    cv32e41s_wpt_filter #(
        .NUM_TRIGGERS    (NT),
        .MAX_OUTSTANDING (MO),
        .REQ_W           (REQ_W),
        .RSP_W           (RSP_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .trigger_match_i    (trigger_match_i),
        .core_trans_valid_i (core_trans_valid_i),
        .core_trans_ready_o (core_trans_ready_o),
        .core_trans_i       (core_trans_i),
        .mpu_trans_valid_o  (mpu_trans_valid_o),
        .mpu_trans_ready_i  (mpu_trans_ready_i),
        .mpu_trans_o        (mpu_trans_o),
        .mpu_resp_valid_i   (mpu_resp_valid_i),
        .mpu_resp_i         (mpu_resp_i),
        .core_resp_valid_o  (core_resp_valid_o),
        .core_resp_o        (core_resp_o),
        .core_resp_wpt_o    (core_resp_wpt_o),
        .core_wpt_wait_i    (core_wpt_wait_i),
        .core_wpt_match_o   (core_wpt_match_o),
        .outstanding_o      (outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then return at the falling edge.
    task automatic step(input logic cv, input logic [NT-1:0] tm, input logic wt,
                        input logic mr, input logic rv, input logic [RSP_W-1:0] rd,
                        input logic [REQ_W-1:0] pl, input logic r = 1'b0);
        @(posedge clk);
        #1;
        rst                = r;
        core_trans_valid_i = cv;
        trigger_match_i    = tm;
        core_wpt_wait_i    = wt;
        mpu_trans_ready_i  = mr;
        mpu_resp_valid_i   = rv;
        mpu_resp_i         = rd;
        core_trans_i       = pl;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic exp_t bus_rsp(input logic [RSP_W-1:0] d);
        exp_t e;
        e.rsp = d;
        e.wpt = '0;
        return e;
    endfunction

    function automatic exp_t syn_rsp(input logic [NT-1:0] m);
        exp_t e;
        e.rsp = '0;
        e.wpt = m;
        return e;
    endfunction

    // Scoreboard: every response seen by the core must be the next expected one.
    always @(negedge clk) begin
        if (!rst && core_resp_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_core_resp", 96'(core_resp_valid_o), 96'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("core_resp",     96'(core_resp_o),     96'(e.rsp));
                check("core_resp_wpt", 96'(core_resp_wpt_o), 96'(e.wpt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        core_trans_valid_i = 1'b0;
        trigger_match_i    = '0;
        core_wpt_wait_i    = 1'b0;
        mpu_trans_ready_i  = 1'b0;
        mpu_resp_valid_i   = 1'b0;
        mpu_resp_i         = '0;
        core_trans_i       = '0;

        // Reset
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle_cycle();
        check("rst_outstanding", 96'(outstanding_o), 96'(0));
        check("rst_resp_valid",  96'(core_resp_valid_o), 96'(0));
        check("rst_resp_wpt",    96'(core_resp_wpt_o), 96'(0));
        check("rst_mpu_valid",   96'(mpu_trans_valid_o), 96'(0));

        // Clean hit with nothing in flight: response one cycle later
        step(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, '0, 72'h11);
        check("t1_ready",      96'(core_trans_ready_o), 96'(1));
        check("t1_mpu_valid",  96'(mpu_trans_valid_o), 96'(0));
        check("t1_wpt_match",  96'(core_wpt_match_o), 96'(4'b0010));
        sb.push_back(syn_rsp(4'b0010));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h12);
        check("t1_resp_valid", 96'(core_resp_valid_o), 96'(1));
        check("t1_resp_block", 96'(core_trans_ready_o), 96'(0));
        check("t1_resp_mpuv",  96'(mpu_trans_valid_o), 96'(0));
        idle_cycle();
        check("t1_back_idle",  96'(core_resp_valid_o), 96'(0));

        // Two transfers in flight, then a hit that has to wait for the drain
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'hA5_0000_0000_0000_0001);
        check("t2_mpu_valid0", 96'(mpu_trans_valid_o), 96'(1));
        check("t2_ready0",     96'(core_trans_ready_o), 96'(1));
        check("t2_mpu_trans",  96'(mpu_trans_o), 96'(72'hA5_0000_0000_0000_0001));
        check("t2_cnt0",       96'(outstanding_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h2);
        check("t2_cnt1",       96'(outstanding_o), 96'(1));
        step(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, '0, 72'h3);        // +0 hit
        check("t2_hit_ready",  96'(core_trans_ready_o), 96'(1));
        check("t2_hit_mpuv",   96'(mpu_trans_valid_o), 96'(0));
        check("t2_cnt2",       96'(outstanding_o), 96'(2));
        for (int i = 1; i <= 2; i++) begin                       // +1, +2
            step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h4);
            check("t2_wait_ready", 96'(core_trans_ready_o), 96'(0));
            check("t2_wait_mpuv",  96'(mpu_trans_valid_o), 96'(0));
        end
        sb.push_back(bus_rsp(40'hAB_CDEF_0123));
        step(1'b1, '0, 1'b0, 1'b1, 1'b1, 40'hAB_CDEF_0123, 72'h4); // +3
        check("t2_fwd_valid",  96'(core_resp_valid_o), 96'(1));
        check("t2_fwd_ready",  96'(core_trans_ready_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h4);             // +4
        check("t2_gap_valid",  96'(core_resp_valid_o), 96'(0));
        sb.push_back(bus_rsp(40'h12_3456_789A));
        sb.push_back(syn_rsp(4'b0001));
        step(1'b1, '0, 1'b0, 1'b1, 1'b1, 40'h12_3456_789A, 72'h4); // +5
        check("t2_fwd2_ready", 96'(core_trans_ready_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h4);             // +6
        check("t2_syn_valid",  96'(core_resp_valid_o), 96'(1));
        check("t2_syn_ready",  96'(core_trans_ready_o), 96'(0));
        check("t2_syn_cnt",    96'(outstanding_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h5);             // +7
        check("t2_next_ready", 96'(core_trans_ready_o), 96'(1));
        check("t2_next_mpuv",  96'(mpu_trans_valid_o), 96'(1));
        sb.push_back(bus_rsp(40'h55));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 40'h55, '0);
        check("t2_drain_cnt",  96'(outstanding_o), 96'(1));

        // Outstanding cap: count 1,2,2,1,2
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h6);
        check("t3_cnt_a",      96'(outstanding_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h7);
        check("t3_cnt_b",      96'(outstanding_o), 96'(1));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h8);
        check("t3_cnt_c",      96'(outstanding_o), 96'(2));
        check("t3_cap_ready",  96'(core_trans_ready_o), 96'(0));
        check("t3_cap_mpuv",   96'(mpu_trans_valid_o), 96'(0));
        sb.push_back(bus_rsp(40'h66));
        step(1'b1, '0, 1'b0, 1'b1, 1'b1, 40'h66, 72'h8);
        check("t3_cnt_d",      96'(outstanding_o), 96'(2));
        check("t3_caprsp_mpuv",96'(mpu_trans_valid_o), 96'(0));
        check("t3_caprsp_rdy", 96'(core_trans_ready_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'h8);
        check("t3_cnt_e",      96'(outstanding_o), 96'(1));
        check("t3_accept_rdy", 96'(core_trans_ready_o), 96'(1));
        check("t3_accept_mpuv",96'(mpu_trans_valid_o), 96'(1));
        idle_cycle();
        check("t3_cnt_f",      96'(outstanding_o), 96'(2));

        // Hit while capped: consumed at once, response after both drains
        step(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, '0, 72'h9);
        check("t4_hit_ready",  96'(core_trans_ready_o), 96'(1));
        check("t4_hit_mpuv",   96'(mpu_trans_valid_o), 96'(0));
        sb.push_back(bus_rsp(40'h77));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 40'h77, '0);
        check("t4_wait_ready", 96'(core_trans_ready_o), 96'(0));
        sb.push_back(bus_rsp(40'h88));
        sb.push_back(syn_rsp(4'b0100));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 40'h88, '0);
        check("t4_wait2_ready",96'(core_trans_ready_o), 96'(0));
        idle_cycle();
        check("t4_syn_valid",  96'(core_resp_valid_o), 96'(1));
        idle_cycle();
        check("t4_done_valid", 96'(core_resp_valid_o), 96'(0));
        check("t4_done_cnt",   96'(outstanding_o), 96'(0));

        // Silent consume: no response, next request passes
        step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, '0, 72'hA);
        check("t5_ready",      96'(core_trans_ready_o), 96'(1));
        check("t5_wpt_match",  96'(core_wpt_match_o), 96'(4'b1000));
        check("t5_mpuv",       96'(mpu_trans_valid_o), 96'(0));
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'hB);
        check("t5_pass_ready", 96'(core_trans_ready_o), 96'(1));
        check("t5_pass_mpuv",  96'(mpu_trans_valid_o), 96'(1));
        check("t5_no_resp",    96'(core_resp_valid_o), 96'(0));
        sb.push_back(bus_rsp(40'h99));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 40'h99, '0);
        check("t5_cnt",        96'(outstanding_o), 96'(1));
        idle_cycle();
        check("t5_cnt_drain",  96'(outstanding_o), 96'(0));

        // Reset while waiting drops the pending match
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, 72'hC);
        step(1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, '0, 72'hD);
        check("t6_hit_ready",  96'(core_trans_ready_o), 96'(1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        check("t6_wait_ready", 96'(core_trans_ready_o), 96'(0));
        check("t6_wait_cnt",   96'(outstanding_o), 96'(1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        check("t6_rst_cnt",    96'(outstanding_o), 96'(0));
        check("t6_rst_idle",   96'(core_trans_ready_o), 96'(1));
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            check("t6_no_resp", 96'(core_resp_valid_o), 96'(0));
        end

        check("sb_empty", 96'(sb.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
